// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the BCD-to-segment encoder and the scan decoder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Segment vectors are ordered {a,b,c,d,e,f,g}: bit 6 = a, bit 0 = g, 1 = segment lit.
package seg7_pkg;

    localparam int SEG_W = 7;

    // Bit positions of each segment inside a pattern vector
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    // Nibble reported for any pattern that is not an exact digit glyph
    localparam logic [3:0] BCD_ERR = 4'hF;

    // Builds a pattern vector from individual segment levels in {a..g} order
    function automatic logic [SEG_W-1:0] seg_pack(input logic a, input logic b,
                                                  input logic c, input logic d,
                                                  input logic e, input logic f,
                                                  input logic g);
        return {a, b, c, d, e, f, g};
    endfunction

    // Forward map used by the encoder; non-decimal nibbles blank the digit
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] digit);
        logic [SEG_W-1:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Decodes one 7-segment pattern back to a BCD digit; illegal patterns flag err.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its input).
// Ports: seg   - pattern {a..g}, 1 = lit
//        bcd   - decoded digit, BCD_ERR when the pattern is not an exact glyph
//        err   - high for any pattern outside the ten legal glyphs
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       bcd,
    output logic             err
);

    always_comb begin
        bcd = BCD_ERR;
        err = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a BCD frame from a multiplexed 7-segment bus with per-digit debounce.
// Latency: held pattern captured STABLE_CYCLES-1 edges after first sample; frame one edge later.
// Backpressure: none; the display bus cannot be stalled, frames publish as soon as complete.
// Ports: clk, rst_n         - clock and async active-low reset
//        seg_in, dig_en     - segment levels {a..g} and one-hot digit select
//        bcd_out, digit_err - last complete frame, nibble/bit i = digit i
//        frame_valid        - one-cycle pulse when bcd_out/digit_err update
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEG_W-1:0]        seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    localparam int         SAMP_W  = NUM_DIGITS + SEG_W;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [SAMP_W-1:0]       samp_q;
    logic [SAMP_W-1:0]       samp_cur;
    logic [7:0]              cnt_q;
    logic [7:0]              cnt_nxt;
    logic                    one_hot;
    logic                    same;
    logic                    capture;

    logic [3:0]              dec_bcd;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] slot_bcd_q;
    logic [NUM_DIGITS-1:0]   slot_err_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic [NUM_DIGITS-1:0]   seen_nxt;
    logic                    publish_q;
    logic                    frame_done;

    assign samp_cur = {dig_en, seg_in};
    assign one_hot  = $onehot(dig_en);
    assign same     = (samp_cur == samp_q);

    always_comb begin
        cnt_nxt = 8'd0;
        if (!one_hot) begin
            cnt_nxt = 8'd0;
        end else if (same) begin
            cnt_nxt = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end else begin
            cnt_nxt = 8'd1;
        end
    end

    // Capture on reaching the threshold, but not while a run simply stays
    // saturated. The explicit "same" term matters when STABLE_CYCLES is 1:
    // a new pattern then restarts at 1 == CNT_MAX and must still capture.
    assign capture = one_hot && (cnt_nxt == CNT_MAX) && !(same && (cnt_q == CNT_MAX));

    seg7_to_bcd u_dec (
        .seg (seg_in),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // On the publish edge the old frame's seen bits are dropped first, so a
    // capture on that same edge is the first entry of the new frame.
    always_comb begin
        seen_nxt = publish_q ? '0 : seen_q;
        if (capture) begin
            seen_nxt = seen_nxt | dig_en;
        end
    end

    assign frame_done = capture && (&seen_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q      <= '0;
            cnt_q       <= '0;
            slot_bcd_q  <= '0;
            slot_err_q  <= '0;
            seen_q      <= '0;
            publish_q   <= 1'b0;
            bcd_out     <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            samp_q      <= samp_cur;
            cnt_q       <= cnt_nxt;
            seen_q      <= seen_nxt;
            publish_q   <= frame_done;
            frame_valid <= publish_q;
            if (publish_q) begin
                bcd_out   <= slot_bcd_q;
                digit_err <= slot_err_q;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && dig_en[i]) begin
                    slot_bcd_q[4*i +: 4] <= dec_bcd;
                    slot_err_q[i]        <= dec_err;
                end
            end
        end
    end

endmodule
